// File: rtl/pst_if_queue_pkg.sv
// Shared core constants for the fetch stage: default instruction-memory geometry,
// reset PC and the word-to-byte address helper used by the debug PC output.
package pst_if_queue_pkg;

  localparam int unsigned IM_ADDR_BIT      = 10;
  localparam int unsigned INST_BIT         = 32;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_addr);
    return word_addr << 2;
  endfunction

endpackage

// File: rtl/pst_if_queue_inst_mem.sv
// Combinational instruction ROM, word addressed; contents are supplied by whoever owns the array.
module inst_mem #(
  parameter int unsigned ADDR_BIT  = 10,
  parameter int unsigned INST_BIT  = 32,
  parameter string       PROG_PATH = "benchmark.hex"
) (
  input  logic [ADDR_BIT-1:0] addr_i,
  output logic [INST_BIT-1:0] inst_o
);

  logic [INST_BIT-1:0] mem [2**ADDR_BIT];

  assign inst_o = mem[addr_i];

endmodule

// File: rtl/pst_if_queue_sync_fifo.sv
// Registered synchronous FIFO with flush; head is read straight from storage, zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // When full, a push is only legal if the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pst_if_queue.sv
// Instruction-fetch stage: PC register plus a decoupling queue of {pc, inst} pairs,
// with execute-driven redirect/flush and a halt that stops fetching but lets decode drain.
module pst_if_queue
  import pst_if_queue_pkg::*;
#(
  parameter int unsigned ADDR_BIT  = IM_ADDR_BIT,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RESET_PC  = RESET_PC_DEFAULT,
  parameter string       PROG_PATH = "benchmark.hex"
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       halt,
  input  logic                       redir_valid,
  input  logic [ADDR_BIT-1:0]        redir_pc,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [ADDR_BIT-1:0]        out_pc,
  output logic [ADDR_BIT-1:0]        out_pc_4,
  output logic [INST_BIT-1:0]        out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                dbg_pc
);

  localparam int unsigned ENTRY_W = ADDR_BIT + INST_BIT;

  logic [ADDR_BIT-1:0] pc_q, pc_d;
  logic [INST_BIT-1:0] fetch_inst;
  logic [ENTRY_W-1:0]  head_entry;
  logic                fifo_full, fifo_empty;
  logic                push, pop;

  inst_mem #(
    .ADDR_BIT (ADDR_BIT),
    .INST_BIT (INST_BIT),
    .PROG_PATH(PROG_PATH)
  ) u_imem (
    .addr_i(pc_q),
    .inst_o(fetch_inst)
  );

  // A redirect squashes both ends of the queue in its own cycle.
  assign pop  = ~fifo_empty & out_ready & ~redir_valid;
  assign push = en & ~halt & ~redir_valid & (~fifo_full | pop);

  always_comb begin
    pc_d = pc_q;
    if (redir_valid)
      pc_d = redir_pc;
    else if (push)
      pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      pc_q <= ADDR_BIT'(RESET_PC);
    else
      pc_q <= pc_d;
  end

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redir_valid),
    .wdata_i({pc_q, fetch_inst}),
    .rdata_o(head_entry),
    .count_o(count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_pc    = head_entry[ENTRY_W-1 -: ADDR_BIT];
  assign out_inst  = head_entry[INST_BIT-1:0];
  assign out_pc_4  = fifo_empty ? '0 : out_pc + 1'b1;
  assign dbg_pc    = word_to_byte_addr(32'(pc_q));

endmodule

// File: tb/tb_pst_if_queue.sv
// Directed bench for the fetch queue: a reference queue of expected {pc, inst} pairs is
// filled as fetches are predicted and compared against the head every cycle.
module tb_pst_if_queue;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n, en, halt, redir_valid, out_ready;
  logic [AW-1:0] redir_pc;
  logic          out_valid;
  logic [AW-1:0] out_pc, out_pc_4;
  logic [31:0]   out_inst;
  logic [CW-1:0] count;
  logic [31:0]   dbg_pc;

  always #5 clk = ~clk;

  pst_if_queue #(
    .ADDR_BIT (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (0),
    .PROG_PATH("")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .halt       (halt),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_pc_4   (out_pc_4),
    .out_inst   (out_inst),
    .count      (count),
    .dbg_pc     (dbg_pc)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   inst;
  } entry_t;

  entry_t        sb_q[$];
  int            acc[$];
  logic [AW-1:0] m_pc;
  int            passed = 0;
  int            failed = 0;
  int            total  = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0] nxt;
    logic [31:0]   dbg_exp;
    dbg_exp = 32'(m_pc) << 2;
    chk("out_valid", out_valid, sb_q.size() != 0);
    chk("count", count, sb_q.size());
    chk("dbg_pc", dbg_pc, dbg_exp);
    if (sb_q.size() != 0) begin
      nxt = sb_q[0].pc + 1'b1;
      chk("out_pc", out_pc, sb_q[0].pc);
      chk("out_inst", out_inst, sb_q[0].inst);
      chk("out_pc_4", out_pc_4, nxt);
    end else begin
      chk("empty_pc", out_pc, 0);
      chk("empty_inst", out_inst, 0);
      chk("empty_pc_4", out_pc_4, 0);
    end
  endtask

  // Predict the effect of the current inputs, advance one clock, then compare.
  task automatic cycle();
    entry_t e;
    bit     pop_m, push_m, full_m;
    if (!rst_n) begin
      sb_q.delete();
      m_pc = '0;
    end else if (redir_valid) begin
      sb_q.delete();
      m_pc = redir_pc;
    end else begin
      full_m = (sb_q.size() == DEPTH);
      pop_m  = (sb_q.size() != 0) && out_ready;
      push_m = en && !halt && (!full_m || pop_m);
      if (pop_m) begin
        e = sb_q.pop_front();
        acc.push_back(int'(e.pc));
      end
      if (push_m) begin
        e.pc   = m_pc;
        e.inst = mem_word(m_pc);
        sb_q.push_back(e);
        m_pc = m_pc + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    en          = 1'b0;
    halt        = 1'b0;
    redir_valid = 1'b0;
    out_ready   = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    acc.delete();
  endtask

  task automatic check_acc(input string tag, input int start, input int n);
    chk({tag, "_n"}, acc.size(), n);
    if (acc.size() == n)
      for (int i = 0; i < n; i++) chk(tag, acc[i], (start + i) % (1 << AW));
    acc.delete();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) dut.u_imem.mem[i] = 32'h1000_0000 + 32'(i);
    rst_n = 1'b0; en = 1'b0; halt = 1'b0; redir_valid = 1'b0; redir_pc = '0; out_ready = 1'b0;
    m_pc = '0;

    // Reset state, then streaming with decode always ready
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_dbg_pc", dbg_pc, 0);
    en = 1'b1; out_ready = 1'b1;
    cycle();
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_pc", out_pc, 0);
    chk("t1_first_inst", out_inst, 32'h1000_0000);
    repeat (5) cycle();
    check_acc("t1_order", 0, 5);

    // Decode stalled: queue fills and pc stops, then drains without a gap
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    repeat (8) cycle();
    chk("t2_full_count", count, 4);
    chk("t2_pc_stop", dbg_pc, 32'h10);
    out_ready = 1'b1;
    repeat (4) cycle();
    check_acc("t2_drain", 0, 4);
    chk("t2_count_hold", count, 4);
    chk("t2_pc_run", dbg_pc, 32'h20);

    // Redirect with three entries queued, then back-to-back redirects
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    repeat (3) cycle();
    chk("t3_pre_count", count, 3);
    redir_valid = 1'b1; redir_pc = 10'h02A; out_ready = 1'b1;
    cycle();
    chk("t3_t1_valid", out_valid, 0);
    chk("t3_t1_count", count, 0);
    redir_valid = 1'b0;
    cycle();
    chk("t3_t2_valid", out_valid, 1);
    chk("t3_t2_pc", out_pc, 10'h02A);
    chk("t3_t2_inst", out_inst, 32'h1000_002A);
    repeat (3) cycle();
    check_acc("t3_post", 'h2A, 3);
    redir_valid = 1'b1; redir_pc = 10'h100;
    cycle();
    redir_pc = 10'h200;
    cycle();
    redir_valid = 1'b0;
    cycle();
    chk("t3_b2b_pc", out_pc, 10'h200);

    // PC wrap at the top of the address space
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    redir_valid = 1'b1; redir_pc = 10'h3FE;
    cycle();
    redir_valid = 1'b0;
    cycle();
    chk("t4_pc_3fe", out_pc, 10'h3FE);
    cycle();
    chk("t4_pc_3ff", out_pc, 10'h3FF);
    chk("t4_pc4_wrap", out_pc_4, 10'h000);
    cycle();
    chk("t4_pc_000", out_pc, 10'h000);
    chk("t4_inst_000", out_inst, 32'h1000_0000);

    // Halt drains a full queue with pc frozen; resume; then en=0 drain
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    repeat (6) cycle();
    chk("t5_full", count, 4);
    halt = 1'b1; out_ready = 1'b1;
    repeat (6) cycle();
    chk("t5_empty_valid", out_valid, 0);
    chk("t5_empty_count", count, 0);
    chk("t5_pc_frozen", dbg_pc, 32'h10);
    check_acc("t5_drain", 0, 4);
    halt = 1'b0;
    cycle();
    chk("t5_resume_pc", out_pc, 4);
    en = 1'b0;
    repeat (3) cycle();
    chk("t5_en0_valid", out_valid, 0);
    chk("t5_en0_pc", dbg_pc, 32'h14);

    // Reset coincident with a redirect mid-stream
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    repeat (5) cycle();
    rst_n = 1'b0; redir_valid = 1'b1; redir_pc = 10'h055;
    cycle();
    chk("t6_pc", dbg_pc, 0);
    chk("t6_count", count, 0);
    chk("t6_valid", out_valid, 0);
    rst_n = 1'b1; redir_valid = 1'b0;
    cycle();
    chk("t6_head_pc", out_pc, 0);
    chk("t6_head_valid", out_valid, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
